serial_pattern_tx: RTL and testbench

Parallel-to-serial transmitter that drives single-bit serial streams into the sequence-detector datapath. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, with a qualifying valid. A programmable idle gap can be inserted between words. It is the stimulus-side counterpart of the serial pattern detectors: its `out` connects directly to a detector's `in`.

---
 rtl/serial_pkg.sv | 12 +
 rtl/serial_pattern_tx.sv | 142 ++++++++++++++
 tb/tb_serial_pattern_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial pattern transmit/detect datapath.
package serial_pkg;

  // Transmitter FSM states. The ST_ prefix keeps the literals from colliding
  // with the GAP parameter of the transmitter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

endpackage : serial_pkg

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock with a qualifying valid, optionally
// followed by GAP idle cycles per word.
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(WIDTH - 2);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  tx_state_t        r_state;
  logic [WIDTH-1:0] r_shift;
  logic [IDX_W-1:0] r_bit_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_out;
  logic             r_out_valid;
  logic             r_word_done;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_last_bit;
  logic             w_ready;
  logic             w_handshake;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic             w_cur_bit;
  logic [WIDTH-1:0] w_next_shift;

  // r_bit_idx tracks the bit currently on out, so the last bit is visible
  // while the next word may already be handed over (back-to-back, GAP=0).
  assign w_last_bit  = (r_state == ST_SHIFT) && (r_bit_idx == LAST_IDX);
  assign w_ready     = !rst && ((r_state == ST_IDLE) || (w_last_bit && (GAP == 0)));
  assign w_handshake = din_valid && w_ready;

  // The first bit leaves straight from din; the shift register holds the
  // remaining bits, already advanced by one position.
  assign w_load_bit   = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
  assign w_load_shift = (MSB_FIRST != 0) ? {din[WIDTH-2:0], 1'b0}
                                         : {1'b0, din[WIDTH-1:1]};
  assign w_cur_bit    = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_next_shift = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_shift[WIDTH-1:1]};

  // FSM, shift register, bit/gap counters and registered outputs.
  // NOTE: non-blocking assignments throughout, so every register in this
  // block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_gap_cnt   <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_word_done <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      r_word_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_state     <= ST_SHIFT;
            r_shift     <= w_load_shift;
            r_bit_idx   <= '0;
            r_out       <= w_load_bit;
            r_out_valid <= 1'b1;
          end else begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_last_bit) begin
            if (w_handshake) begin
              // Back-to-back word: no bubble between last and first bit.
              r_shift     <= w_load_shift;
              r_bit_idx   <= '0;
              r_out       <= w_load_bit;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
              r_gap_cnt   <= '0;
              r_out       <= 1'b0;
              r_out_valid <= 1'b0;
            end
          end else begin
            r_shift     <= w_next_shift;
            r_bit_idx   <= r_bit_idx + 1'b1;
            r_out       <= w_cur_bit;
            r_out_valid <= 1'b1;
            if (r_bit_idx == PENULT_IDX) begin
              // The bit being launched now is the word's last one.
              r_word_done <= 1'b1;
              r_word_cnt  <= r_word_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          r_out       <= 1'b0;
          r_out_valid <= 1'b0;
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out       <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready = w_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);
  assign word_done = r_word_done;
  assign word_cnt  = r_word_cnt;

endmodule : serial_pattern_tx

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three configurations side by side, driven by
// directed and random words and compared against an expected bit stream
// derived from word values and the configuration.
module tb_serial_pattern_tx;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  int         sel;

  // Instance 0: WIDTH=4, GAP=0, MSB first, 2-bit counter.
  logic       a_ready, a_out, a_ov, a_busy, a_done;
  logic [1:0] a_cnt;
  // Instance 1: WIDTH=4, GAP=2, MSB first.
  logic        b_ready, b_out, b_ov, b_busy, b_done;
  logic [15:0] b_cnt;
  // Instance 2: WIDTH=8, GAP=0, LSB first.
  logic        c_ready, c_out, c_ov, c_busy, c_done;
  logic [15:0] c_cnt;

  serial_pattern_tx #(.WIDTH(4), .GAP(0), .MSB_FIRST(1), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .din(din[3:0]), .din_valid(din_valid && sel == 0),
    .din_ready(a_ready), .out(a_out), .out_valid(a_ov), .busy(a_busy),
    .word_done(a_done), .word_cnt(a_cnt)
  );

  serial_pattern_tx #(.WIDTH(4), .GAP(2), .MSB_FIRST(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .din(din[3:0]), .din_valid(din_valid && sel == 1),
    .din_ready(b_ready), .out(b_out), .out_valid(b_ov), .busy(b_busy),
    .word_done(b_done), .word_cnt(b_cnt)
  );

  serial_pattern_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid && sel == 2),
    .din_ready(c_ready), .out(c_out), .out_valid(c_ov), .busy(c_busy),
    .word_done(c_done), .word_cnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs of the instance currently under test.
  logic        obs_ready, obs_out, obs_ov, obs_busy, obs_done;
  logic [31:0] obs_cnt;
  always_comb begin
    obs_ready = a_ready; obs_out = a_out; obs_ov = a_ov;
    obs_busy  = a_busy;  obs_done = a_done; obs_cnt = {30'd0, a_cnt};
    if (sel == 1) begin
      obs_ready = b_ready; obs_out = b_out; obs_ov = b_ov;
      obs_busy  = b_busy;  obs_done = b_done; obs_cnt = {16'd0, b_cnt};
    end else if (sel == 2) begin
      obs_ready = c_ready; obs_out = c_out; obs_ov = c_ov;
      obs_busy  = c_busy;  obs_done = c_done; obs_cnt = {16'd0, c_cnt};
    end
  end

  function automatic int cfg_width(input int s); return (s == 2) ? 8 : 4; endfunction
  function automatic int cfg_gap(input int s);   return (s == 1) ? 2 : 0; endfunction
  function automatic int cfg_msb(input int s);   return (s == 2) ? 0 : 1; endfunction
  function automatic int cfg_mod(input int s);   return (s == 0) ? 4 : 65536; endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_model[3];
  logic [7:0] wq[$];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready, input logic exp_busy);
    check({tag, "_out"},   32'(obs_out), 32'd0);
    check({tag, "_ov"},    32'(obs_ov), 32'd0);
    check({tag, "_done"},  32'(obs_done), 32'd0);
    check({tag, "_busy"},  32'(obs_busy), 32'(exp_busy));
    check({tag, "_ready"}, 32'(obs_ready), 32'(exp_ready));
  endtask

  // Sends every word in wq to instance s with din_valid held high across
  // words, checking the serial stream cycle by cycle. Instance must be idle.
  task automatic send_words(input int s);
    int w, g, msb, pos, n;
    logic exp_bit;
    w = cfg_width(s); g = cfg_gap(s); msb = cfg_msb(s); n = wq.size();
    sel = s;
    din = wq[0];
    din_valid = 1'b1;
    #1;
    check("ready_at_idle", 32'(obs_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < w; b++) begin
        @(posedge clk); #1;
        pos = (msb != 0) ? (w - 1 - b) : b;
        exp_bit = 1'(wq[i] >> pos);
        if (b == w - 1) cnt_model[s] = (cnt_model[s] + 1) % cfg_mod(s);
        check("bit",       32'(obs_out), 32'(exp_bit));
        check("bit_valid", 32'(obs_ov), 32'd1);
        check("busy",      32'(obs_busy), 32'd1);
        check("word_done", 32'(obs_done), 32'(b == w - 1));
        check("word_cnt",  obs_cnt, 32'(cnt_model[s]));
        check("ready_in_shift", 32'(obs_ready), 32'((b == w - 1) && (g == 0)));
        if (b == 0) din = 8'($urandom);  // ignored: no handshake mid-word
        if (b == w - 1) begin
          if (i < n - 1) din = wq[i + 1];
          else din_valid = 1'b0;
        end
      end
      if (g > 0 || i == n - 1) begin
        for (int k = 0; k < g; k++) begin
          @(posedge clk); #1;
          check_quiet("gap", 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        check_quiet("idle", 1'b1, 1'b0);
      end
    end
    wq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; sel = 0;
    foreach (cnt_model[i]) cnt_model[i] = 0;

    // Reset values, and din_ready forced low while rst is high.
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_quiet("in_reset", 1'b0, 1'b0);
      check("in_reset_cnt", obs_cnt, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_quiet("after_reset", 1'b1, 1'b0);
    end

    // Single word 4'b1011, MSB first.
    wq.push_back(8'hB);
    send_words(0);

    // Back-to-back 4'hB then 4'h5 with din_valid held.
    wq.push_back(8'hB); wq.push_back(8'h5);
    send_words(0);

    // Reset on the 2nd bit of 4'hB: word abandoned, no word_done.
    sel = 0; din = 8'h0B; din_valid = 1'b1;
    @(posedge clk); #1;
    check("abort_bit0", 32'(obs_out), 32'd1);
    din_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_bit1", 32'(obs_out), 32'd0);
    check("abort_bit1_valid", 32'(obs_ov), 32'd1);
    rst = 1'b1; #1;
    check("ready_low_in_reset", 32'(obs_ready), 32'd0);
    @(posedge clk); #1;
    foreach (cnt_model[i]) cnt_model[i] = 0;
    check_quiet("aborted", 1'b0, 1'b0);
    check("aborted_cnt", obs_cnt, 32'd0);
    rst = 1'b0;
    wq.push_back(8'h9);
    send_words(0);

    // Five back-to-back random words: counter wraps through 0.
    for (int i = 0; i < 5; i++) wq.push_back(8'($urandom_range(0, 15)));
    send_words(0);

    // GAP=2: two words 4'hB, then three random words.
    wq.push_back(8'hB); wq.push_back(8'hB);
    send_words(1);
    for (int i = 0; i < 3; i++) wq.push_back(8'($urandom_range(0, 15)));
    send_words(1);

    // LSB first, WIDTH=8: 8'h0D then four random words back to back.
    wq.push_back(8'h0D);
    for (int i = 0; i < 4; i++) wq.push_back(8'($urandom));
    send_words(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_pattern_tx
